// File: rtl/cmp_pipe_stream_if.sv
`default_nettype none
// ============================================================================
// Module      : cmp_pipe_stream_if
// Description : Operand/result stream bundle for the pipelined comparator.
//               The slave modport is the comparator side; the master modport
//               is the producer/consumer side driving operands and out_ready.
// Revision    : 1.0 - initial release
// ============================================================================
interface cmp_pipe_stream_if #(
  parameter int BITS = 32
);
  // Operand side
  logic            in_valid;
  logic            in_ready;
  logic [BITS-1:0] A;
  logic [BITS-1:0] B;
  logic            signed_mode;

  // Result side
  logic            out_valid;
  logic            out_ready;
  logic            lt;
  logic            eq;
  logic            gt;
  logic [BITS-1:0] min_val;
  logic [BITS-1:0] max_val;

  modport master (
    output in_valid, A, B, signed_mode, out_ready,
    input  in_ready, out_valid, lt, eq, gt, min_val, max_val
  );

  modport slave (
    input  in_valid, A, B, signed_mode, out_ready,
    output in_ready, out_valid, lt, eq, gt, min_val, max_val
  );
endinterface
`default_nettype wire

// File: rtl/cmp_pipe_stream.sv
`default_nettype none
// ============================================================================
// Module      : cmp_pipe_stream
// Description : Pipelined magnitude comparator with valid/ready handshake.
//               Resolves CHUNK bits per stage, MSB chunk first, in unsigned
//               or two's-complement mode. Produces lt/eq/gt, min/max and
//               saturating per-outcome counters of accepted results.
// Revision    : 1.0 - initial release
// ============================================================================
module cmp_pipe_stream #(
  parameter int BITS  = 32,
  parameter int CHUNK = 8,
  parameter int CNT_W = 16
) (
  input  wire              clk,
  input  wire              rst_n,
  cmp_pipe_stream_if.slave stream,
  input  wire              cnt_clr,
  output logic [CNT_W-1:0] lt_cnt,
  output logic [CNT_W-1:0] eq_cnt,
  output logic [CNT_W-1:0] gt_cnt
);

  // Pipeline depth equals the number of chunks; not user-overridable.
  localparam int STAGES = BITS / CHUNK;

  localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

  // Refuse to elaborate a geometry that cannot be split into whole chunks.
  if ((BITS < 2) || (CHUNK < 1) || ((BITS % CHUNK) != 0)) begin : g_param_check
    $error("cmp_pipe_stream: BITS must be >= 2 and an exact multiple of CHUNK");
  end

  // --------------------------------------------------------------------------
  // Stage registers: valid, decision flags and the untouched operands, which
  // ride along so the final stage can pick min/max without re-deriving them.
  // --------------------------------------------------------------------------
  logic            r_vld [STAGES];
  logic            r_dec [STAGES];
  logic            r_agt [STAGES];
  logic [BITS-1:0] r_a   [STAGES];
  logic [BITS-1:0] r_b   [STAGES];

  // Per-stage inputs (stage 0 from the port, stage k from stage k-1)
  logic            w_src_vld [STAGES];
  logic            w_src_dec [STAGES];
  logic            w_src_agt [STAGES];
  logic [BITS-1:0] w_src_a   [STAGES];
  logic [BITS-1:0] w_src_b   [STAGES];

  // Per-stage next decision flags
  logic            w_dec_n [STAGES];
  logic            w_agt_n [STAGES];

  // Chunk under inspection (scratch inside the compare loop)
  logic [CHUNK-1:0] w_ca;
  logic [CHUNK-1:0] w_cb;

  logic w_stall;
  logic w_adv;
  logic w_xfer;
  logic w_dec_o;
  logic w_agt_o;
  logic w_gt_raw;
  logic w_lt;
  logic w_eq;
  logic w_gt;

  logic [CNT_W-1:0] r_lt_cnt;
  logic [CNT_W-1:0] r_eq_cnt;
  logic [CNT_W-1:0] r_gt_cnt;

  // The whole pipe freezes only when a result is presented and refused.
  assign w_stall         = r_vld[STAGES-1] & ~stream.out_ready;
  assign w_adv           = ~w_stall;
  assign stream.in_ready = ~w_stall;

  // Route each stage's inputs: port operands into stage 0, previous stage after.
  always_comb begin
    w_src_vld[0] = stream.in_valid;
    w_src_dec[0] = 1'b0;
    w_src_agt[0] = 1'b0;
    w_src_a[0]   = stream.A;
    w_src_b[0]   = stream.B;
    for (int k = 1; k < STAGES; k++) begin
      w_src_vld[k] = r_vld[k-1];
      w_src_dec[k] = r_dec[k-1];
      w_src_agt[k] = r_agt[k-1];
      w_src_a[k]   = r_a[k-1];
      w_src_b[k]   = r_b[k-1];
    end
  end

  // Chunk compare per stage; flipping both MSBs in stage 0 maps two's-complement
  // order onto unsigned order, so every later stage is a plain unsigned compare.
  always_comb begin
    w_ca = '0;
    w_cb = '0;
    for (int k = 0; k < STAGES; k++) begin
      w_ca = w_src_a[k][BITS-1-k*CHUNK -: CHUNK];
      w_cb = w_src_b[k][BITS-1-k*CHUNK -: CHUNK];
      if (k == 0) begin
        w_ca[CHUNK-1] = w_ca[CHUNK-1] ^ stream.signed_mode;
        w_cb[CHUNK-1] = w_cb[CHUNK-1] ^ stream.signed_mode;
      end
      if (w_src_dec[k]) begin
        // A more significant chunk already settled the outcome.
        w_dec_n[k] = 1'b1;
        w_agt_n[k] = w_src_agt[k];
      end else if (w_ca != w_cb) begin
        w_dec_n[k] = 1'b1;
        w_agt_n[k] = (w_ca > w_cb);
      end else begin
        w_dec_n[k] = 1'b0;
        w_agt_n[k] = 1'b0;
      end
    end
  end

  // Advance all stages together unless the output is stalled; reset discards
  // everything in flight so no partial result can ever surface.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        r_vld[k] <= 1'b0;
        r_dec[k] <= 1'b0;
        r_agt[k] <= 1'b0;
        r_a[k]   <= '0;
        r_b[k]   <= '0;
      end
    end else if (w_adv) begin
      for (int k = 0; k < STAGES; k++) begin
        r_vld[k] <= w_src_vld[k];
        r_dec[k] <= w_dec_n[k];
        r_agt[k] <= w_agt_n[k];
        r_a[k]   <= w_src_a[k];
        r_b[k]   <= w_src_b[k];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Result decode from the last stage. Flags are qualified by valid so they
  // read 0 on bubbles; an undecided pair is equal.
  // --------------------------------------------------------------------------
  assign w_dec_o  = r_dec[STAGES-1];
  assign w_agt_o  = r_agt[STAGES-1];
  assign w_gt_raw = w_dec_o & w_agt_o;

  assign w_lt = r_vld[STAGES-1] & w_dec_o & ~w_agt_o;
  assign w_eq = r_vld[STAGES-1] & ~w_dec_o;
  assign w_gt = r_vld[STAGES-1] & w_gt_raw;

  assign stream.out_valid = r_vld[STAGES-1];
  assign stream.lt        = w_lt;
  assign stream.eq        = w_eq;
  assign stream.gt        = w_gt;
  // On equality min takes A and max takes B.
  assign stream.min_val   = w_gt_raw ? r_b[STAGES-1] : r_a[STAGES-1];
  assign stream.max_val   = w_gt_raw ? r_a[STAGES-1] : r_b[STAGES-1];

  // A result is consumed only on an output handshake.
  assign w_xfer = r_vld[STAGES-1] & stream.out_ready;

  // Saturating outcome counters; clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lt_cnt <= '0;
      r_eq_cnt <= '0;
      r_gt_cnt <= '0;
    end else if (cnt_clr) begin
      r_lt_cnt <= '0;
      r_eq_cnt <= '0;
      r_gt_cnt <= '0;
    end else if (w_xfer) begin
      if (w_lt && (r_lt_cnt != c_CNT_MAX)) r_lt_cnt <= r_lt_cnt + 1'b1;
      if (w_eq && (r_eq_cnt != c_CNT_MAX)) r_eq_cnt <= r_eq_cnt + 1'b1;
      if (w_gt && (r_gt_cnt != c_CNT_MAX)) r_gt_cnt <= r_gt_cnt + 1'b1;
    end
  end

  assign lt_cnt = r_lt_cnt;
  assign eq_cnt = r_eq_cnt;
  assign gt_cnt = r_gt_cnt;

endmodule
`default_nettype wire

// File: tb/tb_cmp_pipe_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_cmp_pipe_stream
// Description : Self-checking bench for cmp_pipe_stream. Three instances:
//               8/4 (two stages), 32/8 (four stages), 8/8 with 3-bit counters
//               (single stage). Expected results are queued at drive time
//               and popped when each instance presents a result.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cmp_pipe_stream;

  typedef struct packed {
    logic        lt;
    logic        eq;
    logic        gt;
    logic [31:0] mn;
    logic [31:0] mx;
  } res_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  res_t q8[$];
  res_t q32[$];
  res_t q1[$];

  logic        clr8  = 1'b0;
  logic        clr32 = 1'b0;
  logic        clr1  = 1'b0;
  logic [15:0] lt8, eq8, gt8;
  logic [15:0] lt32, eq32, gt32;
  logic [2:0]  lt1, eq1, gt1;

  cmp_pipe_stream_if #(.BITS(8))  if8 ();
  cmp_pipe_stream_if #(.BITS(32)) if32 ();
  cmp_pipe_stream_if #(.BITS(8))  if1 ();

  cmp_pipe_stream #(.BITS(8), .CHUNK(4), .CNT_W(16)) u8 (
    .clk(clk), .rst_n(rst_n), .stream(if8), .cnt_clr(clr8),
    .lt_cnt(lt8), .eq_cnt(eq8), .gt_cnt(gt8)
  );
  cmp_pipe_stream #(.BITS(32), .CHUNK(8), .CNT_W(16)) u32 (
    .clk(clk), .rst_n(rst_n), .stream(if32), .cnt_clr(clr32),
    .lt_cnt(lt32), .eq_cnt(eq32), .gt_cnt(gt32)
  );
  cmp_pipe_stream #(.BITS(8), .CHUNK(8), .CNT_W(3)) u1 (
    .clk(clk), .rst_n(rst_n), .stream(if1), .cnt_clr(clr1),
    .lt_cnt(lt1), .eq_cnt(eq1), .gt_cnt(gt1)
  );

  always #5 clk = ~clk;

  // Reference: interpret operands as w-bit integers and compare numerically.
  function automatic res_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic sm, input int w);
    longint va;
    longint vb;
    res_t   r;
    va = longint'(a);
    vb = longint'(b);
    if (sm && a[w-1]) va = va - (longint'(1) << w);
    if (sm && b[w-1]) vb = vb - (longint'(1) << w);
    r.lt = (va < vb);
    r.eq = (va == vb);
    r.gt = (va > vb);
    r.mn = r.gt ? b : a;
    r.mx = r.gt ? a : b;
    return r;
  endfunction

  // Result monitors: a handshake seen at the falling edge completes at the next rise.
  always @(negedge clk) begin
    if (rst_n && if8.out_valid && if8.out_ready) begin
      n_tests++;
      if (q8.size() == 0) begin
        n_fail++;
        $display("FAIL u8_unexpected: got out_valid=1, required no pending result");
      end else begin
        res_t e;
        e = q8.pop_front();
        if ({if8.lt, if8.eq, if8.gt, if8.min_val, if8.max_val} !==
            {e.lt, e.eq, e.gt, e.mn[7:0], e.mx[7:0]}) begin
          n_fail++;
          $display("FAIL u8_result: got lt/eq/gt=%b%b%b min=%h max=%h, required %b%b%b min=%h max=%h",
                   if8.lt, if8.eq, if8.gt, if8.min_val, if8.max_val,
                   e.lt, e.eq, e.gt, e.mn[7:0], e.mx[7:0]);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && if32.out_valid && if32.out_ready) begin
      n_tests++;
      if (q32.size() == 0) begin
        n_fail++;
        $display("FAIL u32_unexpected: got out_valid=1, required no pending result");
      end else begin
        res_t e;
        e = q32.pop_front();
        if ({if32.lt, if32.eq, if32.gt, if32.min_val, if32.max_val} !==
            {e.lt, e.eq, e.gt, e.mn, e.mx}) begin
          n_fail++;
          $display("FAIL u32_result: got lt/eq/gt=%b%b%b min=%h max=%h, required %b%b%b min=%h max=%h",
                   if32.lt, if32.eq, if32.gt, if32.min_val, if32.max_val,
                   e.lt, e.eq, e.gt, e.mn, e.mx);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && if1.out_valid && if1.out_ready) begin
      n_tests++;
      if (q1.size() == 0) begin
        n_fail++;
        $display("FAIL u1_unexpected: got out_valid=1, required no pending result");
      end else begin
        res_t e;
        e = q1.pop_front();
        if ({if1.lt, if1.eq, if1.gt, if1.min_val, if1.max_val} !==
            {e.lt, e.eq, e.gt, e.mn[7:0], e.mx[7:0]}) begin
          n_fail++;
          $display("FAIL u1_result: got lt/eq/gt=%b%b%b min=%h max=%h, required %b%b%b min=%h max=%h",
                   if1.lt, if1.eq, if1.gt, if1.min_val, if1.max_val,
                   e.lt, e.eq, e.gt, e.mn[7:0], e.mx[7:0]);
        end
      end
    end
  end

  // Hard time limit in case a handshake never completes.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers ----------------
  task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic sm);
    @(posedge clk); #1;
    if8.in_valid = 1'b1; if8.A = a; if8.B = b; if8.signed_mode = sm;
    q8.push_back(model({24'd0, a}, {24'd0, b}, sm, 8));
  endtask

  task automatic send32(input logic [31:0] a, input logic [31:0] b, input logic sm);
    @(posedge clk); #1;
    if32.in_valid = 1'b1; if32.A = a; if32.B = b; if32.signed_mode = sm;
    q32.push_back(model(a, b, sm, 32));
  endtask

  task automatic send1(input logic [7:0] a, input logic [7:0] b, input logic sm);
    @(posedge clk); #1;
    if1.in_valid = 1'b1; if1.A = a; if1.B = b; if1.signed_mode = sm;
    q1.push_back(model({24'd0, a}, {24'd0, b}, sm, 8));
  endtask

  task automatic idle_all;
    @(posedge clk); #1;
    if8.in_valid = 1'b0; if32.in_valid = 1'b0; if1.in_valid = 1'b0;
  endtask

  task automatic drain;
    int n;
    n = 0;
    while ((q8.size() + q32.size() + q1.size()) != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    n_tests++;
    if ((q8.size() + q32.size() + q1.size()) != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: pending u8=%0d u32=%0d u1=%0d, required 0",
               q8.size(), q32.size(), q1.size());
    end
    repeat (3) @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    n_tests++;
    if ({if8.out_valid, if8.lt, if8.eq, if8.gt, if8.min_val, if8.max_val, lt8, eq8, gt8} !== '0) begin
      n_fail++;
      $display("FAIL reset_u8: got vld=%b flags=%b%b%b min=%h max=%h cnt=%0d/%0d/%0d, required all 0",
               if8.out_valid, if8.lt, if8.eq, if8.gt, if8.min_val, if8.max_val, lt8, eq8, gt8);
    end
    n_tests++;
    if ({if32.out_valid, if32.lt, if32.eq, if32.gt, if32.min_val, if32.max_val, lt32, eq32, gt32} !== '0) begin
      n_fail++;
      $display("FAIL reset_u32: got vld=%b flags=%b%b%b min=%h max=%h cnt=%0d/%0d/%0d, required all 0",
               if32.out_valid, if32.lt, if32.eq, if32.gt, if32.min_val, if32.max_val, lt32, eq32, gt32);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({if8.in_ready, if32.in_ready, if1.in_ready} !== 3'b111) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b%b%b, required 111", if8.in_ready, if32.in_ready, if1.in_ready);
    end
  endtask

  task automatic test_unsigned8;
    int k;
    send8(8'h80, 8'h7F, 1'b0);
    idle_all;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!if8.out_valid && k < 10);
    n_tests++;
    if (k !== 2) begin
      n_fail++;
      $display("FAIL u8_latency: got %0d cycles, required 2", k);
    end
    drain;
  endtask

  task automatic test_signed8;
    send8(8'h80, 8'h7F, 1'b1);
    send8(8'hA5, 8'hA5, 1'b1);
    idle_all;
    drain;
    n_tests++;
    if ({lt8, eq8, gt8} !== {16'd1, 16'd1, 16'd1}) begin
      n_fail++;
      $display("FAIL u8_counts: got lt/eq/gt=%0d/%0d/%0d, required 1/1/1", lt8, eq8, gt8);
    end
    // Sign boundary and decisions that only the low chunk can make
    send8(8'h00, 8'hFF, 1'b1);
    send8(8'h7F, 8'h80, 1'b0);
    send8(8'h01, 8'h00, 1'b1);
    send8(8'hF0, 8'hF1, 1'b0);
    send8(8'h5A, 8'h5A, 1'b0);
    idle_all;
    drain;
  endtask

  task automatic test_back_to_back;
    int          first, last, nv, s;
    bit          rdy_ok;
    logic [31:0] a, b;
    logic        sm;
    first = -1; last = -1; nv = 0; rdy_ok = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (c < 20) begin
        a  = $urandom;
        sm = 1'($urandom_range(0, 1));
        if (c % 5 == 0)      b = a;
        else if (c % 5 == 1) b = {a[31:8], a[7:0] ^ 8'($urandom_range(1, 255))};
        else                 b = $urandom;
        if32.in_valid = 1'b1; if32.A = a; if32.B = b; if32.signed_mode = sm;
        q32.push_back(model(a, b, sm, 32));
      end else begin
        if32.in_valid = 1'b0;
      end
      @(negedge clk);
      if (c < 20 && if32.in_ready !== 1'b1) rdy_ok = 1'b0;
      if (if32.out_valid) begin
        nv++;
        if (first < 0) first = c;
        last = c;
      end
    end
    n_tests++;
    if (first !== 4 || last !== 23 || nv !== 20) begin
      n_fail++;
      $display("FAIL b2b_timing: got first=%0d last=%0d count=%0d, required 4/23/20", first, last, nv);
    end
    n_tests++;
    if (!rdy_ok) begin
      n_fail++;
      $display("FAIL b2b_in_ready: got in_ready low while streaming, required 1");
    end
    drain;
    s = int'(lt32) + int'(eq32) + int'(gt32);
    n_tests++;
    if (s !== 20 || eq32 !== 16'd4) begin
      n_fail++;
      $display("FAIL b2b_counts: got sum=%0d eq=%0d, required sum=20 eq=4", s, eq32);
    end
  endtask

  task automatic test_stall;
    int          acc;
    logic [31:0] a, b;
    logic        sm;
    logic [70:0] snap;
    acc = 0;
    @(posedge clk); #1;
    if32.out_ready = 1'b0;
    a = $urandom; b = $urandom; sm = 1'($urandom_range(0, 1));
    if32.in_valid = 1'b1; if32.A = a; if32.B = b; if32.signed_mode = sm;
    for (int g = 0; g < 10; g++) begin
      @(negedge clk);
      if (!if32.in_ready) break;
      q32.push_back(model(a, b, sm, 32));
      acc++;
      @(posedge clk); #1;
      a = $urandom; b = $urandom; sm = 1'($urandom_range(0, 1));
      if32.A = a; if32.B = b; if32.signed_mode = sm;
    end
    n_tests++;
    if (acc !== 4) begin
      n_fail++;
      $display("FAIL stall_fill: got %0d accepted before in_ready fell, required 4", acc);
    end
    snap = {if32.out_valid, if32.lt, if32.eq, if32.gt, 3'b000, if32.min_val, if32.max_val};
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_tests++;
      if ({if32.in_ready, if32.out_valid, if32.lt, if32.eq, if32.gt, 3'b000, if32.min_val, if32.max_val}
          !== {1'b0, snap}) begin
        n_fail++;
        $display("FAIL stall_hold: cycle %0d got rdy=%b out=%h, required rdy=0 out=%h", c,
                 if32.in_ready, {if32.out_valid, if32.lt, if32.eq, if32.gt, 3'b000,
                 if32.min_val, if32.max_val}, snap);
      end
    end
    @(posedge clk); #1;
    if32.out_ready = 1'b1;
    @(negedge clk);
    n_tests++;
    if (if32.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_release: got in_ready=%b, required 1", if32.in_ready);
    end
    q32.push_back(model(a, b, sm, 32));
    @(posedge clk); #1;
    if32.in_valid = 1'b0;
    drain;
  endtask

  task automatic test_saturate;
    logic [7:0] v;
    int         s;
    for (int i = 0; i < 10; i++) begin
      v = 8'($urandom);
      send1(v, v, 1'($urandom_range(0, 1)));
    end
    idle_all;
    drain;
    n_tests++;
    if ({lt1, eq1, gt1} !== {3'd0, 3'd7, 3'd0}) begin
      n_fail++;
      $display("FAIL sat_counts: got lt/eq/gt=%0d/%0d/%0d, required 0/7/0", lt1, eq1, gt1);
    end
    send1(8'h3C, 8'h3C, 1'b0);
    @(posedge clk); #1;
    if1.in_valid = 1'b0;
    clr1 = 1'b1;
    @(negedge clk);
    n_tests++;
    if (if1.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL stage1_latency: got out_valid=%b one cycle after accept, required 1", if1.out_valid);
    end
    @(posedge clk); #1;
    clr1 = 1'b0;
    @(negedge clk);
    n_tests++;
    if (eq1 !== 3'd0) begin
      n_fail++;
      $display("FAIL clr_priority: got eq_cnt=%0d, required 0", eq1);
    end
    // Mixed single-stage compares after the clear
    send1(8'h80, 8'h7F, 1'b1);
    send1(8'h80, 8'h7F, 1'b0);
    for (int i = 0; i < 4; i++) send1(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
    idle_all;
    drain;
    s = int'(lt1) + int'(eq1) + int'(gt1);
    n_tests++;
    if (s !== 6) begin
      n_fail++;
      $display("FAIL u1_count_sum: got %0d, required 6", s);
    end
  endtask

  task automatic test_async_reset;
    int k;
    bit stale;
    // Four accepted: one presented, three behind it; none are queued as they must vanish.
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if32.in_valid = 1'b1; if32.A = $urandom; if32.B = $urandom; if32.signed_mode = 1'b0;
    end
    @(posedge clk); #1;
    if32.in_valid = 1'b0;
    n_tests++;
    if (if32.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL areset_pre: got out_valid=%b, required 1", if32.out_valid);
    end
    #1 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({if32.out_valid, if32.lt, if32.eq, if32.gt, lt32, eq32, gt32, lt8, eq8, gt8} !== '0) begin
      n_fail++;
      $display("FAIL areset_now: got vld=%b flags=%b%b%b cnt32=%0d/%0d/%0d cnt8=%0d/%0d/%0d, required all 0",
               if32.out_valid, if32.lt, if32.eq, if32.gt, lt32, eq32, gt32, lt8, eq8, gt8);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    stale = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (if32.out_valid !== 1'b0) stale = 1'b1;
    end
    n_tests++;
    if (stale) begin
      n_fail++;
      $display("FAIL areset_stale: got out_valid=1 after reset, required 0");
    end
    send32(32'hFFFF0000, 32'hFFFF0001, 1'b1);
    idle_all;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!if32.out_valid && k < 10);
    n_tests++;
    if (k !== 4) begin
      n_fail++;
      $display("FAIL areset_latency: got %0d cycles, required 4", k);
    end
    drain;
    n_tests++;
    if ({lt32, eq32, gt32} !== {16'd1, 16'd0, 16'd0}) begin
      n_fail++;
      $display("FAIL areset_counts: got lt/eq/gt=%0d/%0d/%0d, required 1/0/0", lt32, eq32, gt32);
    end
  endtask

  initial begin
    if8.in_valid  = 1'b0; if8.A  = '0; if8.B  = '0; if8.signed_mode  = 1'b0; if8.out_ready  = 1'b1;
    if32.in_valid = 1'b0; if32.A = '0; if32.B = '0; if32.signed_mode = 1'b0; if32.out_ready = 1'b1;
    if1.in_valid  = 1'b0; if1.A  = '0; if1.B  = '0; if1.signed_mode  = 1'b0; if1.out_ready  = 1'b1;
    test_reset;
    test_unsigned8;
    test_signed8;
    test_back_to_back;
    test_stall;
    test_saturate;
    test_async_reset;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
